// File: rtl/btn_pkg.sv
// Shared constants, repeat-FSM state type and counter-width helper for the button path.
package btn_pkg;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_ENTER = 2;

    localparam int DEF_DEBOUNCE_CYC     = 1_000_000;
    localparam int DEF_REPEAT_DELAY_CYC = 50_000_000;
    localparam int DEF_REPEAT_RATE_CYC  = 20_000_000;
    localparam logic [2:0] DEF_REPEAT_MASK = 3'b011;

    typedef enum logic [1:0] {
        REP_IDLE,
        REP_DELAY,
        REP_RATE
    } rep_state_e;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer, counter debounce, rising-edge one-shot.
// Optional auto-repeat FSM is built only when BTN_AUTOREPEAT_EN is defined and REPEAT_EN is set.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter bit REPEAT_EN        = 1'b0,
    parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
`endif
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_raw_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYC);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          stable_dly_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;
    logic          press;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Held-through-reset buttons still pulse: the delayed copy also resets to 0.
    assign press = stable_q & ~stable_dly_q;

`ifdef BTN_AUTOREPEAT_EN
    logic rep_fire;

    if (REPEAT_EN) begin : g_rep
        localparam int RMAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                                    : REPEAT_RATE_CYC;
        localparam int RW = cnt_width(RMAX);
        localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYC - 1);
        localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYC - 1);

        rep_state_e    rep_state_q, rep_state_d;
        logic [RW-1:0] rep_cnt_q, rep_cnt_d;
        logic          fire_d;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rep_state_q <= REP_IDLE;
                rep_cnt_q   <= '0;
            end else begin
                rep_state_q <= rep_state_d;
                rep_cnt_q   <= rep_cnt_d;
            end
        end

        // Counting starts on the edge that launches the initial pulse.
        always_comb begin
            rep_state_d = rep_state_q;
            rep_cnt_d   = rep_cnt_q;
            fire_d      = 1'b0;
            if (!stable_q) begin
                rep_state_d = REP_IDLE;
                rep_cnt_d   = '0;
            end else begin
                case (rep_state_q)
                    REP_IDLE: begin
                        if (press) begin
                            rep_state_d = REP_DELAY;
                            rep_cnt_d   = '0;
                        end
                    end
                    REP_DELAY: begin
                        if (rep_cnt_q == DELAY_LAST) begin
                            fire_d      = 1'b1;
                            rep_state_d = REP_RATE;
                            rep_cnt_d   = '0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + RW'(1);
                        end
                    end
                    REP_RATE: begin
                        if (rep_cnt_q == RATE_LAST) begin
                            fire_d    = 1'b1;
                            rep_cnt_d = '0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + RW'(1);
                        end
                    end
                    default: begin
                        rep_state_d = REP_IDLE;
                        rep_cnt_d   = '0;
                    end
                endcase
            end
        end

        assign rep_fire = fire_d;
    end else begin : g_norep
        assign rep_fire = 1'b0;
    end

    assign pulse_d = press | rep_fire;
`else
    assign pulse_d = press;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
            pulse_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_raw_i;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            pulse_q      <= pulse_d;
        end
    end

    assign level_o = stable_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/btn_conditioner.sv
// Board push-buttons to clean level and one-cycle press pulses, one independent channel each.
// Define BTN_AUTOREPEAT_EN to enable auto-repeat on channels selected by REPEAT_MASK.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int               N_BTN            = 3,
    parameter int               DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int               REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int               REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC,
    parameter logic [N_BTN-1:0] REPEAT_MASK      = N_BTN'(DEF_REPEAT_MASK)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYC     (DEBOUNCE_CYC)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_EN        (REPEAT_MASK[i]),
            .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
`endif
        ) u_ch (
            .clk_i     (clk),
            .rst_ni    (rst_n),
            .btn_raw_i (btn_raw[i]),
            .level_o   (btn_level[i]),
            .pulse_o   (btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomized and directed bench for btn_conditioner against a sample-window reference model.
module tb_btn_conditioner;
    import btn_pkg::*;

    localparam int D  = 8;
    localparam int RD = 20;
    localparam int RR = 5;
    localparam logic [2:0] RMASK = 3'b011;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] btn_raw = 3'b000;
    logic [2:0] btn_level, btn_pulse;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    btn_conditioner #(
        .N_BTN(3), .DEBOUNCE_CYC(D), .REPEAT_DELAY_CYC(RD),
        .REPEAT_RATE_CYC(RR), .REPEAT_MASK(RMASK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_pulse(btn_pulse)
    );

    always #5 clk = ~clk;

    // Reference: level flips to v when the last D raw samples taken two edges back all equal v.
    bit         hist[3][$];
    logic [2:0] exp_level = 3'b000;
    logic [2:0] exp_pulse = 3'b000;
    bit         rose[3];
    int         p_edge[3];
    int         edge_n = 0;

    always @(posedge clk or negedge rst_n) begin
        bit lvl_pre, fire, all_same;
        int dt, sz;
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                hist[c].delete();
                rose[c]   = 1'b0;
                p_edge[c] = -1;
            end
            exp_level = 3'b000;
            exp_pulse = 3'b000;
        end else begin
            edge_n++;
            for (int c = 0; c < 3; c++) begin
                lvl_pre = exp_level[c];
                fire    = 1'b0;
                if (!lvl_pre) begin
                    p_edge[c] = -1;
                end else if (AR && RMASK[c] && p_edge[c] >= 0) begin
                    dt   = edge_n - p_edge[c];
                    fire = (dt == RD) || (dt > RD && ((dt - RD) % RR) == 0);
                end
                exp_pulse[c] = rose[c] | fire;
                if (rose[c]) p_edge[c] = edge_n;
                rose[c] = 1'b0;
                sz = hist[c].size();
                if (sz >= D + 1) begin
                    all_same = 1'b1;
                    for (int j = sz - 1 - D; j <= sz - 2; j++)
                        if (hist[c][j] == lvl_pre) all_same = 1'b0;
                    if (all_same) begin
                        exp_level[c] = ~lvl_pre;
                        rose[c]      = ~lvl_pre;
                    end
                end
                hist[c].push_back(btn_raw[c]);
                if (hist[c].size() > D + 2) void'(hist[c].pop_front());
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        btn_raw = 3'($urandom);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if (btn_level !== 3'b000 || btn_pulse !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_outputs: level=%b pulse=%b required 000/000", btn_level, btn_pulse);
            end else n_pass++;
        end
        btn_raw = 3'b000;
        rst_n   = 1'b1;
        for (int e = 1; e <= D + 4; e++) begin
            tick();
            n_chk++;
            if (btn_level !== 3'b000 || btn_pulse !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_idle e%0d: level=%b pulse=%b required 000/000", e, btn_level, btn_pulse);
            end else n_pass++;
        end
    endtask

    task automatic test_single_press();
        int first_lvl = -1, first_pls = -1, np = 0, other = 0;
        btn_raw[BTN_UP] = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            n_chk++;
            if (btn_level !== exp_level || btn_pulse !== exp_pulse) begin
                n_fail++;
                $display("FAIL single_model e%0d: level=%b pulse=%b expected %b/%b", e, btn_level, btn_pulse, exp_level, exp_pulse);
            end else n_pass++;
            if (btn_level[BTN_UP] === 1'b1 && first_lvl < 0) first_lvl = e;
            if (btn_pulse[BTN_UP] === 1'b1) begin
                np++;
                if (first_pls < 0) first_pls = e;
            end
            if (btn_pulse[2:1] !== 2'b00) other++;
        end
        n_chk++;
        if (first_lvl !== D + 2) begin
            n_fail++; $display("FAIL single_level_edge: got %0d required %0d", first_lvl, D + 2);
        end else n_pass++;
        n_chk++;
        if (first_pls !== D + 3) begin
            n_fail++; $display("FAIL single_pulse_edge: got %0d required %0d", first_pls, D + 3);
        end else n_pass++;
        n_chk++;
        if (np !== (AR ? 3 : 1) || other !== 0) begin
            n_fail++; $display("FAIL single_pulse_count: up=%0d others=%0d required %0d/0", np, other, AR ? 3 : 1);
        end else n_pass++;
        btn_raw[BTN_UP] = 1'b0;
        np = 0;
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (btn_pulse !== 3'b000) np++;
        end
        n_chk++;
        if (np !== 0 || btn_level !== 3'b000) begin
            n_fail++; $display("FAIL release_no_pulse: pulses=%0d level=%b required 0/000", np, btn_level);
        end else n_pass++;
    endtask

    task automatic test_glitch();
        int seen = 0;
        btn_raw[BTN_DOWN] = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            if (e == 6) btn_raw[BTN_DOWN] = 1'b0;
            tick();
            if (btn_level[BTN_DOWN] !== 1'b0 || btn_pulse[BTN_DOWN] !== 1'b0) seen++;
            n_chk++;
            if (btn_level !== exp_level || btn_pulse !== exp_pulse) begin
                n_fail++;
                $display("FAIL glitch_model e%0d: level=%b pulse=%b expected %b/%b", e, btn_level, btn_pulse, exp_level, exp_pulse);
            end else n_pass++;
        end
        n_chk++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL glitch_suppressed: active cycles=%0d required 0", seen);
        end else n_pass++;
    endtask

    task automatic test_bounce();
        int np = 0, first_pls = -1;
        for (int i = 0; i < 30; i++) begin
            btn_raw[BTN_ENTER] = (((i / 3) % 2) == 0);
            tick();
            if (btn_pulse !== 3'b000 || btn_level !== 3'b000) np++;
        end
        btn_raw[BTN_ENTER] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (btn_pulse[BTN_ENTER] === 1'b1) begin
                np++;
                if (first_pls < 0) first_pls = e;
            end
        end
        n_chk++;
        if (np !== 1 || first_pls !== D + 3) begin
            n_fail++; $display("FAIL bounce_press: pulses=%0d edge=%0d required 1/%0d", np, first_pls, D + 3);
        end else n_pass++;
        np = 0;
        for (int i = 0; i < 30; i++) begin
            btn_raw[BTN_ENTER] = (((i / 3) % 2) != 0);
            tick();
            if (btn_pulse !== 3'b000) np++;
            n_chk++;
            if (btn_level !== exp_level || btn_pulse !== exp_pulse) begin
                n_fail++;
                $display("FAIL bounce_model i%0d: level=%b pulse=%b expected %b/%b", i, btn_level, btn_pulse, exp_level, exp_pulse);
            end else n_pass++;
        end
        btn_raw[BTN_ENTER] = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (btn_pulse !== 3'b000) np++;
        end
        n_chk++;
        if (np !== 0 || btn_level !== 3'b000) begin
            n_fail++; $display("FAIL bounce_release: pulses=%0d level=%b required 0/000", np, btn_level);
        end else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [2:0] at10 = 'x, at11 = 'x, at12 = 'x;
        btn_raw = 3'b111;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == D + 2) at10 = btn_pulse;
            if (e == D + 3) at11 = btn_pulse;
            if (e == D + 4) at12 = btn_pulse;
        end
        n_chk++;
        if (at10 !== 3'b000 || at11 !== 3'b111 || at12 !== 3'b000) begin
            n_fail++; $display("FAIL simultaneous: pulse %b,%b,%b required 000,111,000", at10, at11, at12);
        end else n_pass++;
        btn_raw = 3'b000;
        for (int e = 1; e <= 15; e++) tick();
    endtask

    task automatic test_reset_mid();
        int np = 0, first_pls = -1, bad = 0;
        btn_raw[BTN_UP] = 1'b1;
        for (int e = 1; e <= 7; e++) tick();
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (btn_level !== 3'b000 || btn_pulse !== 3'b000) begin
            n_fail++; $display("FAIL reset_async: level=%b pulse=%b required 000/000", btn_level, btn_pulse);
        end else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (btn_level !== 3'b000 || btn_pulse !== 3'b000) bad++;
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (btn_pulse[BTN_UP] === 1'b1) begin
                np++;
                if (first_pls < 0) first_pls = e;
            end
        end
        n_chk++;
        if (bad !== 0 || np !== 1 || first_pls !== D + 3) begin
            n_fail++; $display("FAIL reset_mid: held_bad=%0d pulses=%0d edge=%0d required 0/1/%0d", bad, np, first_pls, D + 3);
        end else n_pass++;
        btn_raw[BTN_UP] = 1'b0;
        for (int e = 1; e <= 15; e++) tick();
    endtask

    task automatic test_autorepeat();
        int np = 0;
        bit want;
        btn_raw[BTN_UP] = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            tick();
            want = (e == D + 3) ||
                   (AR && e >= D + 3 + RD && ((e - (D + 3 + RD)) % RR) == 0);
            n_chk++;
            if (btn_pulse[BTN_UP] !== want) begin
                n_fail++; $display("FAIL repeat_up e%0d: pulse=%b required %b", e, btn_pulse[BTN_UP], want);
            end else n_pass++;
        end
        btn_raw[BTN_UP] = 1'b0;
        for (int e = 1; e <= 15; e++) tick();
        btn_raw[BTN_ENTER] = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            tick();
            if (btn_pulse[BTN_ENTER] === 1'b1) np++;
        end
        n_chk++;
        if (np !== 1) begin
            n_fail++; $display("FAIL repeat_enter: pulses=%0d required 1", np);
        end else n_pass++;
        btn_raw[BTN_ENTER] = 1'b0;
        for (int e = 1; e <= 15; e++) tick();
    endtask

    task automatic test_random();
        int seg[3];
        for (int c = 0; c < 3; c++) seg[c] = $urandom_range(1, 40);
        for (int cyc = 0; cyc < 900; cyc++) begin
            if (cyc == 450) rst_n = 1'b0;
            if (cyc == 453) rst_n = 1'b1;
            tick();
            n_chk++;
            if (btn_level !== exp_level || btn_pulse !== exp_pulse) begin
                n_fail++;
                $display("FAIL random_model c%0d: level=%b pulse=%b expected %b/%b", cyc, btn_level, btn_pulse, exp_level, exp_pulse);
            end else n_pass++;
            for (int c = 0; c < 3; c++) begin
                seg[c]--;
                if (seg[c] <= 0) begin
                    btn_raw[c] = ~btn_raw[c];
                    seg[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(9, 45);
                end
            end
        end
        btn_raw = 3'b000;
        for (int e = 1; e <= 15; e++) tick();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_autorepeat();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
